// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX boundary register with load-use bubble insertion,
// branch flush, back-end stall hold and writeback refresh of held operands.
module id_ex_pipe_reg #(
    parameter int CW_WIDTH = 128,
    parameter int XLEN     = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid_i,
    input  logic [CW_WIDTH-1:0] id_ctrl_i,
    input  logic [4:0]          id_rd_i,
    input  logic [4:0]          id_rs1_i,
    input  logic [4:0]          id_rs2_i,
    input  logic [XLEN-1:0]     id_rs1_data_i,
    input  logic [XLEN-1:0]     id_rs2_data_i,
    input  logic [XLEN-1:0]     id_imm_i,
    input  logic                id_is_load_i,
    input  logic                ex_stall_i,
    input  logic                flush_i,
    input  logic                wb_we_i,
    input  logic [4:0]          wb_rd_i,
    input  logic [XLEN-1:0]     wb_data_i,
    output logic                id_stall_o,
    output logic                ex_valid_o,
    output logic [CW_WIDTH-1:0] ex_ctrl_o,
    output logic [4:0]          ex_rd_o,
    output logic [4:0]          ex_rs1_o,
    output logic [4:0]          ex_rs2_o,
    output logic [XLEN-1:0]     ex_rs1_data_o,
    output logic [XLEN-1:0]     ex_rs2_data_o,
    output logic [XLEN-1:0]     ex_imm_o,
    output logic                ex_is_load_o,
    output logic [CNT_W-1:0]    bubble_cnt_o
);
    typedef struct packed {
        logic                valid;
        logic [CW_WIDTH-1:0] ctrl;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic                is_load;
    } ex_t;

    ex_t              ex_q, ex_d, cap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_hit, hazard;
    logic [XLEN-1:0]  byp1, byp2;

    assign wb_hit = wb_we_i & (wb_rd_i != 5'd0);
    // x0 always reads as zero, whatever the regfile port returns
    assign byp1 = (id_rs1_i == 5'd0) ? '0 : (wb_hit && wb_rd_i == id_rs1_i) ? wb_data_i : id_rs1_data_i;
    assign byp2 = (id_rs2_i == 5'd0) ? '0 : (wb_hit && wb_rd_i == id_rs2_i) ? wb_data_i : id_rs2_data_i;

    assign hazard = id_valid_i & ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0)
                  & ((id_rs1_i == ex_q.rd) | (id_rs2_i == ex_q.rd));
    assign id_stall_o = ~flush_i & (ex_stall_i | hazard);

    always_comb begin
        cap.valid    = id_valid_i;
        cap.ctrl     = id_ctrl_i;
        cap.rd       = id_rd_i;
        cap.rs1      = id_rs1_i;
        cap.rs2      = id_rs2_i;
        cap.rs1_data = byp1;
        cap.rs2_data = byp2;
        cap.imm      = id_imm_i;
        cap.is_load  = id_is_load_i;
        ex_d         = ex_q;
        cnt_d        = cnt_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (ex_stall_i) begin
            ex_d.rs1_data = (wb_hit && wb_rd_i == ex_q.rs1) ? wb_data_i : ex_q.rs1_data;
            ex_d.rs2_data = (wb_hit && wb_rd_i == ex_q.rs2) ? wb_data_i : ex_q.rs2_data;
        end else if (hazard) begin
            ex_d  = '0;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else begin
            ex_d = cap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign ex_ctrl_o     = ex_q.ctrl;
    assign ex_rd_o       = ex_q.rd;
    assign ex_rs1_o      = ex_q.rs1;
    assign ex_rs2_o      = ex_q.rs2;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_is_load_o  = ex_q.is_load;
    assign bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed vector table, hand sequences and random stimulus
// against a rule-level reference model; a CNT_W=2 copy checks saturation.
module tb_id_ex_pipe_reg;
    typedef struct {
        logic         v;
        logic [127:0] ctrl;
        logic [4:0]   rd, rs1, rs2;
        logic [31:0]  d1, d2, imm;
        logic         ld, exs, fl, we;
        logic [4:0]   wrd;
        logic [31:0]  wd;
    } in_t;

    typedef struct {
        logic         valid;
        logic [127:0] ctrl;
        logic [4:0]   rd, rs1, rs2;
        logic [31:0]  d1, d2, imm;
        logic         ld;
        int           cnt;
    } st_t;

    typedef struct {
        in_t  i;
        logic st;
        st_t  e;
    } vec_t;

    logic clk = 0, rst = 0;
    logic id_valid_i, id_is_load_i, ex_stall_i, flush_i, wb_we_i;
    logic [127:0] id_ctrl_i;
    logic [4:0] id_rd_i, id_rs1_i, id_rs2_i, wb_rd_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, wb_data_i;
    logic id_stall_o, ex_valid_o, ex_is_load_o;
    logic [127:0] ex_ctrl_o;
    logic [4:0] ex_rd_o, ex_rs1_o, ex_rs2_o;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [15:0] bubble_cnt_o;
    logic s_stall, s_valid, s_ld;
    logic [127:0] s_ctrl;
    logic [4:0] s_rd, s_rs1, s_rs2;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [1:0] s_cnt;
    int n_cmp = 0, n_bad = 0;
    vec_t tbl[19];

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_is_load_i(id_is_load_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .id_stall_o(id_stall_o),
        .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o),
        .ex_rs2_o(ex_rs2_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_is_load_o(ex_is_load_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_is_load_i(id_is_load_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .id_stall_o(s_stall),
        .ex_valid_o(s_valid), .ex_ctrl_o(s_ctrl), .ex_rd_o(s_rd), .ex_rs1_o(s_rs1),
        .ex_rs2_o(s_rs2), .ex_rs1_data_o(s_d1), .ex_rs2_data_o(s_d2),
        .ex_imm_o(s_imm), .ex_is_load_o(s_ld), .bubble_cnt_o(s_cnt)
    );

    function automatic in_t mi(int v, int ctrl, int rd, int rs1, int rs2, int d1, int d2, int imm,
                               int ld, int exs, int fl, int we, int wrd, int wd);
        in_t i;
        i.v = v[0]; i.ctrl = {96'd0, ctrl}; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
        i.d1 = d1; i.d2 = d2; i.imm = imm; i.ld = ld[0]; i.exs = exs[0]; i.fl = fl[0];
        i.we = we[0]; i.wrd = wrd[4:0]; i.wd = wd;
        return i;
    endfunction

    function automatic st_t me(int v, int ctrl, int rd, int rs1, int rs2, int d1, int d2, int imm, int ld, int cnt);
        st_t s;
        s.valid = v[0]; s.ctrl = {96'd0, ctrl}; s.rd = rd[4:0]; s.rs1 = rs1[4:0]; s.rs2 = rs2[4:0];
        s.d1 = d1; s.d2 = d2; s.imm = imm; s.ld = ld[0]; s.cnt = cnt;
        return s;
    endfunction

    function automatic vec_t mv(in_t i, int st, st_t e);
        vec_t r;
        r.i = i; r.st = st[0]; r.e = e;
        return r;
    endfunction

    function automatic st_t zero_st(int cnt);
        return me(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    endfunction

    // Reference model: pipeline rules stated directly, bubble count kept unbounded
    function automatic logic m_hazard(st_t s, in_t i);
        return i.v && s.valid && s.ld && s.rd != 0 && (i.rs1 == s.rd || i.rs2 == s.rd);
    endfunction

    function automatic logic m_stall(st_t s, in_t i);
        return !i.fl && (i.exs || m_hazard(s, i));
    endfunction

    function automatic logic [31:0] fwd(in_t i, logic [4:0] idx, logic [31:0] rf);
        if (idx == 0) return 0;
        if (i.we && i.wrd == idx) return i.wd;
        return rf;
    endfunction

    function automatic st_t m_step(st_t s, in_t i);
        st_t n;
        n = s;
        if (i.fl) n = zero_st(s.cnt);
        else if (i.exs) begin
            n.d1 = fwd(i, s.rs1, s.d1);
            n.d2 = fwd(i, s.rs2, s.d2);
        end else if (m_hazard(s, i)) n = zero_st(s.cnt + 1);
        else begin
            n.valid = i.v; n.ctrl = i.ctrl; n.rd = i.rd; n.rs1 = i.rs1; n.rs2 = i.rs2;
            n.d1 = fwd(i, i.rs1, i.d1); n.d2 = fwd(i, i.rs2, i.d2); n.imm = i.imm; n.ld = i.ld;
        end
        return n;
    endfunction

    function automatic in_t rnd();
        in_t i;
        i.v = 1'($urandom_range(0, 3) != 0);
        i.ctrl = {$urandom, $urandom, $urandom, $urandom};
        i.rd = 5'($urandom_range(0, 3)); i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
        i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
        i.ld = 1'($urandom_range(0, 1));
        i.exs = 1'($urandom_range(0, 4) == 0);
        i.fl = 1'($urandom_range(0, 9) == 0);
        i.we = 1'($urandom_range(0, 1));
        i.wrd = 5'($urandom_range(0, 3)); i.wd = $urandom;
        return i;
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(in_t i);
        id_valid_i = i.v; id_ctrl_i = i.ctrl; id_rd_i = i.rd; id_rs1_i = i.rs1; id_rs2_i = i.rs2;
        id_rs1_data_i = i.d1; id_rs2_data_i = i.d2; id_imm_i = i.imm; id_is_load_i = i.ld;
        ex_stall_i = i.exs; flush_i = i.fl; wb_we_i = i.we; wb_rd_i = i.wrd; wb_data_i = i.wd;
    endtask

    task automatic step(string t, in_t i, logic exp_st);
        drive(i);
        #2;
        chk({t, ".stall"}, id_stall_o, exp_st);
        chk({t, ".stall_small"}, s_stall, exp_st);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string t, st_t m);
        chk({t, ".valid"}, ex_valid_o, m.valid);
        chk({t, ".ctrl"}, ex_ctrl_o, m.ctrl);
        chk({t, ".rd"}, ex_rd_o, m.rd);
        chk({t, ".rs1"}, ex_rs1_o, m.rs1);
        chk({t, ".rs2"}, ex_rs2_o, m.rs2);
        chk({t, ".rs1_data"}, ex_rs1_data_o, m.d1);
        chk({t, ".rs2_data"}, ex_rs2_data_o, m.d2);
        chk({t, ".imm"}, ex_imm_o, m.imm);
        chk({t, ".is_load"}, ex_is_load_o, m.ld);
        chk({t, ".cnt16"}, bubble_cnt_o, (m.cnt > 65535) ? 65535 : m.cnt);
        chk({t, ".cnt2"}, s_cnt, (m.cnt > 3) ? 3 : m.cnt);
        chk({t, ".small_payload"}, {s_valid, s_ctrl, s_rd, s_rs1, s_rs2, s_d1, s_d2, s_imm, s_ld},
            {m.valid, m.ctrl, m.rd, m.rs1, m.rs2, m.d1, m.d2, m.imm, m.ld});
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        in_t lw, use_i, i;
        st_t m;
        //                 v  ctrl    rd rs1 rs2 d1      d2    imm   ld exs fl we wrd wd                st  v ctrl  rd rs1 rs2 d1       d2      imm   ld cnt
        tbl[0]  = mv(mi(1, 'hAB, 5, 0, 0, 0, 0, 'h10, 0, 0, 0, 0, 0, 0), 0, me(1, 'hAB, 5, 0, 0, 0, 0, 'h10, 0, 0));
        tbl[1]  = mv(mi(1, 'h03, 3, 1, 0, 'h100, 0, 4, 1, 0, 0, 0, 0, 0), 0, me(1, 'h03, 3, 1, 0, 'h100, 0, 4, 1, 0));
        tbl[2]  = mv(mi(1, 'h33, 4, 3, 1, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0), 1, me(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[3]  = mv(mi(1, 'h33, 4, 3, 1, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0), 0, me(1, 'h33, 4, 3, 1, 'h11, 'h22, 0, 0, 1));
        tbl[4]  = mv(mi(1, 'h05, 0, 2, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0), 0, me(1, 'h05, 0, 2, 0, 7, 0, 0, 1, 1));
        tbl[5]  = mv(mi(1, 'h33, 4, 0, 1, 'h99, 'h22, 0, 0, 0, 0, 0, 0, 0), 0, me(1, 'h33, 4, 0, 1, 0, 'h22, 0, 0, 1));
        tbl[6]  = mv(mi(1, 'h44, 4, 2, 1, 'h20, 'h10, 0, 0, 0, 0, 0, 0, 0), 0, me(1, 'h44, 4, 2, 1, 'h20, 'h10, 0, 0, 1));
        tbl[7]  = mv(mi(1, 'h77, 9, 5, 6, 1, 2, 3, 1, 1, 0, 0, 0, 0), 1, me(1, 'h44, 4, 2, 1, 'h20, 'h10, 0, 0, 1));
        tbl[8]  = mv(mi(1, 'h77, 9, 5, 6, 1, 2, 3, 1, 1, 0, 1, 2, 'hDEAD), 1, me(1, 'h44, 4, 2, 1, 'hDEAD, 'h10, 0, 0, 1));
        tbl[9]  = mv(mi(1, 'h77, 9, 5, 6, 1, 2, 3, 1, 1, 0, 0, 0, 0), 1, me(1, 'h44, 4, 2, 1, 'hDEAD, 'h10, 0, 0, 1));
        tbl[10] = mv(mi(1, 'h66, 6, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0), 0, me(1, 'h66, 6, 0, 0, 0, 0, 8, 1, 1));
        tbl[11] = mv(mi(1, 'h77, 7, 6, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0), 0, me(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[12] = mv(mi(1, 0, 8, 0, 7, 0, 5, 0, 0, 0, 0, 1, 7, 'h1234), 0, me(1, 0, 8, 0, 7, 0, 'h1234, 0, 0, 1));
        tbl[13] = mv(mi(1, 0, 8, 0, 7, 0, 5, 0, 0, 0, 0, 1, 0, 'h1234), 0, me(1, 0, 8, 0, 7, 0, 5, 0, 0, 1));
        tbl[14] = mv(mi(0, 'h09, 9, 0, 0, 0, 0, 'h55, 0, 0, 0, 0, 0, 0), 0, me(0, 'h09, 9, 0, 0, 0, 0, 'h55, 0, 1));
        tbl[15] = mv(mi(1, 'h0A, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, me(1, 'h0A, 10, 0, 0, 0, 0, 0, 1, 1));
        tbl[16] = mv(mi(1, 'h0B, 11, 0, 10, 0, 3, 0, 0, 0, 0, 0, 0, 0), 1, me(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl[17] = mv(mi(1, 'h0A, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, me(1, 'h0A, 10, 0, 0, 0, 0, 0, 1, 2));
        tbl[18] = mv(mi(0, 'h0C, 12, 10, 0, 'h77, 0, 0, 0, 0, 0, 0, 0, 0), 0, me(0, 'h0C, 12, 10, 0, 'h77, 0, 0, 0, 2));

        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", zero_st(0));
        chk("reset.stall", id_stall_o, 0);
        rst = 1;
        for (int k = 0; k < 19; k++) begin
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].st);
            check_state($sformatf("vec%0d", k), tbl[k].e);
        end

        // Saturation: five load-use pairs, CNT_W=2 copy must stop at 3
        rst = 0; #2; rst = 1;
        lw    = mi(1, 'h1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        use_i = mi(1, 'h2, 6, 5, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("sat_lw%0d", k), lw, 0);
            step($sformatf("sat_use%0d", k), use_i, 1);
            chk($sformatf("sat%0d.cnt16", k), bubble_cnt_o, k);
            chk($sformatf("sat%0d.cnt2", k), s_cnt, (k > 3) ? 3 : k);
            chk($sformatf("sat%0d.bubble", k), ex_valid_o, 0);
        end

        // Asynchronous reset while a bubble sits in EX
        step("ar_lw", lw, 0);
        step("ar_use", use_i, 1);
        chk("ar.cnt_before", bubble_cnt_o, 6);
        #2 rst = 0;
        #1;
        check_state("ar_async", zero_st(0));
        i = use_i;
        i.exs = 1;
        drive(i);
        #1;
        chk("ar.stall_in_reset", id_stall_o, 1);
        @(posedge clk);
        #1;
        check_state("ar_held", zero_st(0));
        rst = 1;
        m = zero_st(0);
        i = mi(1, 'h5A, 3, 1, 2, 'h111, 'h222, 'h333, 1, 0, 0, 0, 0, 0);
        step("ar_first", i, 0);
        m = m_step(m, i);
        check_state("ar_first", m);

        // Random stimulus against the rule-level model
        rst = 0; #2; rst = 1;
        m = zero_st(0);
        for (int k = 0; k < 400; k++) begin
            i = rnd();
            step($sformatf("rnd%0d", k), i, m_stall(m, i));
            m = m_step(m, i);
            check_state($sformatf("rnd%0d", k), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
